// File: rtl/round_robin_tester.sv
// -----------------------------------------------------------------------------
// round_robin_tester
//
// Two independent 4-queue round-robin arbiters fed from the same inputs. One is
// written behaviourally. The other is built only from flip-flops and single
// logic gates. The two must produce identical outputs on every cycle, so any
// divergence between the two output pairs points to a defect in one of them.
//
// Arbitration rule (both arbiters):
//   On each rising edge with rst high and enb high, scan the queues starting
//   just after the current selector S, in the order S+1, S+2, S+3, S (mod 4).
//   Grant the first queue whose buf_empty bit is 0.
//   If no queue is non-empty, selector holds and the grant-valid goes low.
//   With enb low, selector holds and the grant-valid goes low.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   asynchronous, active-low reset
//   enb           in   arbitration enable
//   buf_empty     in   [3:0] per-queue empty flags (1 = queue has no data)
//   selector      out  [1:0] behavioural grant index, registered
//   out_enb       out  behavioural grant-valid, registered
//   sint_selector out  [1:0] structural grant index, registered
//   sint_out_enb  out  structural grant-valid, registered
//
// QUEUE_QUANTITY only supports the value 4, because the selector is fixed at
// 2 bits.
// -----------------------------------------------------------------------------
module round_robin_tester #(
    parameter int QUEUE_QUANTITY = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enb,
    input  logic [QUEUE_QUANTITY-1:0] buf_empty,
    output logic [1:0]                selector,
    output logic                      out_enb,
    output logic [1:0]                sint_selector,
    output logic                      sint_out_enb
);

    // -------------------------------------------------------------------------
    // Behavioural arbiter
    // -------------------------------------------------------------------------
    logic [1:0] beh_sel_q;
    logic       beh_out_q;
    logic [1:0] beh_next_sel;
    logic       beh_found;
    logic [1:0] beh_idx;

    // Offset 4 wraps to S itself, so the current holder is considered last.
    always_comb begin
        beh_found    = 1'b0;
        beh_next_sel = beh_sel_q;
        beh_idx      = beh_sel_q;
        for (int k = 1; k <= 4; k++) begin
            beh_idx = beh_sel_q + k[1:0];
            if (!beh_found && !buf_empty[beh_idx]) begin
                beh_found    = 1'b1;
                beh_next_sel = beh_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beh_sel_q <= 2'b00;
            beh_out_q <= 1'b0;
        end else if (enb) begin
            beh_sel_q <= beh_next_sel;
            beh_out_q <= beh_found;
        end else begin
            beh_out_q <= 1'b0;
        end
    end

    assign selector = beh_sel_q;
    assign out_enb  = beh_out_q;

    // -------------------------------------------------------------------------
    // Structural arbiter: each assign below is a single basic gate
    // (NOT, AND, OR or XOR).
    //
    // The selector is decoded to one-hot form. The non-empty flags are then
    // rotated so that r1..r3 describe queues S+1..S+3. A priority chain picks
    // the smallest offset. The offset is added to S with a 2-bit ripple adder.
    // When no offset in 1..3 is selected, the offset is 0 and the selector
    // holds. This covers both cases where S should be kept: only S is
    // non-empty, or every queue is empty.
    // -------------------------------------------------------------------------
    logic [1:0] st_sel_q;
    logic       st_out_q;

    logic ne0, ne1, ne2, ne3;
    logic s0, s1, ns0, ns1;
    logic d0, d1, d2, d3;

    logic r1_a, r1_b, r1_c, r1_d, r1_ab, r1_cd, r1;
    logic r2_a, r2_b, r2_c, r2_d, r2_ab, r2_cd, r2;
    logic r3_a, r3_b, r3_c, r3_d, r3_ab, r3_cd, r3;

    logic nr1, nr2, g2, g3_a, g3;
    logic any_lo, any_hi, any_ne;
    logic o0, o1, carry, n0, n1_a, n1;
    logic nenb, m0_a, m0_b, m1_a, m1_b, d_sel0, d_sel1, d_out;

    // Invert the empty flags and the current selector bits.
    assign ne0 = ~buf_empty[0];
    assign ne1 = ~buf_empty[1];
    assign ne2 = ~buf_empty[2];
    assign ne3 = ~buf_empty[3];

    assign s0  = st_sel_q[0];
    assign s1  = st_sel_q[1];
    assign ns0 = ~s0;
    assign ns1 = ~s1;

    // Decode the current selector to one-hot.
    assign d0 = ns1 & ns0;
    assign d1 = ns1 & s0;
    assign d2 = s1  & ns0;
    assign d3 = s1  & s0;

    // r1: queue S+1 is non-empty.
    assign r1_a  = d0 & ne1;
    assign r1_b  = d1 & ne2;
    assign r1_c  = d2 & ne3;
    assign r1_d  = d3 & ne0;
    assign r1_ab = r1_a | r1_b;
    assign r1_cd = r1_c | r1_d;
    assign r1    = r1_ab | r1_cd;

    // r2: queue S+2 is non-empty.
    assign r2_a  = d0 & ne2;
    assign r2_b  = d1 & ne3;
    assign r2_c  = d2 & ne0;
    assign r2_d  = d3 & ne1;
    assign r2_ab = r2_a | r2_b;
    assign r2_cd = r2_c | r2_d;
    assign r2    = r2_ab | r2_cd;

    // r3: queue S+3 is non-empty.
    assign r3_a  = d0 & ne3;
    assign r3_b  = d1 & ne0;
    assign r3_c  = d2 & ne1;
    assign r3_d  = d3 & ne2;
    assign r3_ab = r3_a | r3_b;
    assign r3_cd = r3_c | r3_d;
    assign r3    = r3_ab | r3_cd;

    // Priority chain: g1 is r1 itself; g2 and g3 fire only when every
    // smaller offset is empty.
    assign nr1  = ~r1;
    assign nr2  = ~r2;
    assign g2   = nr1 & r2;
    assign g3_a = nr1 & nr2;
    assign g3   = g3_a & r3;

    // Grant-valid: at least one queue holds data.
    assign any_lo = ne0 | ne1;
    assign any_hi = ne2 | ne3;
    assign any_ne = any_lo | any_hi;

    // Encode the chosen offset: 1 -> 01, 2 -> 10, 3 -> 11, none -> 00.
    assign o0 = r1 | g3;
    assign o1 = g2 | g3;

    // 2-bit ripple add of the offset to S.
    assign carry = s0 & o0;
    assign n0    = s0 ^ o0;
    assign n1_a  = s1 ^ o1;
    assign n1    = n1_a ^ carry;

    // enb low: select the held selector and force grant-valid low.
    assign nenb   = ~enb;
    assign m0_a   = enb  & n0;
    assign m0_b   = nenb & s0;
    assign d_sel0 = m0_a | m0_b;
    assign m1_a   = enb  & n1;
    assign m1_b   = nenb & s1;
    assign d_sel1 = m1_a | m1_b;
    assign d_out  = enb & any_ne;

    // Three D flip-flops with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_sel_q <= 2'b00;
            st_out_q <= 1'b0;
        end else begin
            st_sel_q <= {d_sel1, d_sel0};
            st_out_q <= d_out;
        end
    end

    assign sint_selector = st_sel_q;
    assign sint_out_enb  = st_out_q;

endmodule

// File: tb/tb_round_robin_tester.sv
// -----------------------------------------------------------------------------
// Bench for round_robin_tester.
//
// The bench first applies a table of directed vectors. It then runs
// hand-written asynchronous-reset sequences, followed by 1000 random cycles
// whose expected grants come from a small scan model. Every expected
// {selector, out_enb} value is pushed to exp_q when the stimulus is driven.
// It is popped one edge later and compared against both arbiters.
// -----------------------------------------------------------------------------
module tb_round_robin_tester;

    logic       clk;
    logic       rst;
    logic       enb;
    logic [3:0] buf_empty;
    logic [1:0] selector;
    logic       out_enb;
    logic [1:0] sint_selector;
    logic       sint_out_enb;

    round_robin_tester #(.QUEUE_QUANTITY(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .enb           (enb),
        .buf_empty     (buf_empty),
        .selector      (selector),
        .out_enb       (out_enb),
        .sint_selector (sint_selector),
        .sint_out_enb  (sint_out_enb)
    );

    // -------------------------------------------------------------------------
    // Clock
    // -------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    logic [2:0] exp_q[$];
    int         tests_run;
    int         tests_failed;
    logic [1:0] m_sel;

    typedef struct packed {
        logic       enb;
        logic [3:0] be;
        logic [1:0] sel;
        logic       out;
    } vec_t;

    vec_t vecs[$];

    // Compare one output pair against the expected {sel, out}.
    task automatic check_pair(input string name, input logic [1:0] got_sel,
                              input logic got_out, input logic [2:0] exp);
        tests_run++;
        if ({got_sel, got_out} !== exp) begin
            tests_failed++;
            $display("FAIL %s: got sel=%0d out=%0d, required sel=%0d out=%0d",
                     name, got_sel, got_out, exp[2:1], exp[0]);
        end
    endtask

    // Drive one cycle at the falling edge, then sample just after the rising edge.
    task automatic drive_cycle(input logic r, input logic e, input logic [3:0] b,
                               input logic [1:0] es, input logic eo, input string name);
        logic [2:0] exp;
        @(negedge clk);
        rst       = r;
        enb       = e;
        buf_empty = b;
        exp_q.push_back({es, eo});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard queue empty", name);
        end else begin
            exp = exp_q.pop_front();
            check_pair({name, "_beh"}, selector, out_enb, exp);
            check_pair({name, "_sint"}, sint_selector, sint_out_enb, exp);
        end
    endtask

    // Reference scan: the first non-empty queue after m_sel, wrapping back
    // to m_sel itself.
    task automatic model_step(input logic e, input logic [3:0] b, input string name);
        logic [1:0] idx;
        logic [1:0] nsel;
        logic       found;
        nsel  = m_sel;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = m_sel + 2'(k);
            if (!found && !b[idx]) begin
                found = 1'b1;
                nsel  = idx;
            end
        end
        if (!e) begin
            nsel  = m_sel;
            found = 1'b0;
        end
        m_sel = nsel;
        drive_cycle(1'b1, e, b, nsel, found, name);
    endtask

    // Check the outputs of both arbiters directly (asynchronous reset).
    task automatic check_now(input string name);
        check_pair({name, "_beh"}, selector, out_enb, 3'b000);
        check_pair({name, "_sint"}, sint_selector, sint_out_enb, 3'b000);
    endtask

    task automatic add_vec(input logic e, input logic [3:0] b,
                           input logic [1:0] s, input logic o);
        vec_t v;
        v.enb = e;
        v.be  = b;
        v.sel = s;
        v.out = o;
        vecs.push_back(v);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_sel        = 2'b00;

        // Each expected value follows the arbitration rule, starting from
        // selector 0 after reset.
        // Full rotation with every queue non-empty.
        add_vec(1'b1, 4'b0000, 2'd1, 1'b1);
        add_vec(1'b1, 4'b0000, 2'd2, 1'b1);
        add_vec(1'b1, 4'b0000, 2'd3, 1'b1);
        add_vec(1'b1, 4'b0000, 2'd0, 1'b1);
        add_vec(1'b1, 4'b0000, 2'd1, 1'b1);
        // Queue 0 empty: it is skipped without losing a cycle.
        add_vec(1'b1, 4'b0001, 2'd2, 1'b1);
        add_vec(1'b1, 4'b0001, 2'd3, 1'b1);
        add_vec(1'b1, 4'b0001, 2'd1, 1'b1);
        add_vec(1'b1, 4'b0001, 2'd2, 1'b1);
        add_vec(1'b1, 4'b0001, 2'd3, 1'b1);
        // Queue 0 is non-empty again and rejoins the rotation.
        add_vec(1'b1, 4'b0000, 2'd0, 1'b1);
        add_vec(1'b1, 4'b0000, 2'd1, 1'b1);
        // All queues empty: selector holds, grant-valid drops.
        add_vec(1'b1, 4'b1111, 2'd1, 1'b0);
        add_vec(1'b1, 4'b1111, 2'd1, 1'b0);
        // Only queue 2 is non-empty.
        add_vec(1'b1, 4'b1011, 2'd2, 1'b1);
        // Single queue 3 is granted on every cycle.
        add_vec(1'b1, 4'b0111, 2'd3, 1'b1);
        add_vec(1'b1, 4'b0111, 2'd3, 1'b1);
        add_vec(1'b1, 4'b0111, 2'd3, 1'b1);
        // enb low for three cycles: selector is frozen.
        add_vec(1'b0, 4'b0000, 2'd3, 1'b0);
        add_vec(1'b0, 4'b0000, 2'd3, 1'b0);
        add_vec(1'b0, 4'b0000, 2'd3, 1'b0);
        // Rotation resumes from the frozen index.
        add_vec(1'b1, 4'b0000, 2'd0, 1'b1);
        add_vec(1'b1, 4'b0000, 2'd1, 1'b1);
        // Single queue 0, wrapping from index 1.
        add_vec(1'b1, 4'b1110, 2'd0, 1'b1);
        add_vec(1'b1, 4'b1110, 2'd0, 1'b1);
        // Queues 1 and 3 alternate.
        add_vec(1'b1, 4'b0101, 2'd1, 1'b1);
        add_vec(1'b1, 4'b0101, 2'd3, 1'b1);
        add_vec(1'b1, 4'b0101, 2'd1, 1'b1);

        // Reset is asserted at time 0, before the first clock edge.
        rst       = 1'b0;
        enb       = 1'b0;
        buf_empty = 4'b1111;
        #2;
        check_now("reset_async_t0");
        // Reset held across an edge with enable active.
        drive_cycle(1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, "reset_held");

        // Directed table; the first enabled edge after reset grants index 1.
        foreach (vecs[i]) begin
            drive_cycle(1'b1, vecs[i].enb, vecs[i].be, vecs[i].sel, vecs[i].out,
                        $sformatf("table_%0d", i));
        end
        m_sel = 2'd1;

        // Reset asserted between edges, mid-rotation, clears the outputs at once.
        model_step(1'b1, 4'b0000, "pre_mid_reset");
        model_step(1'b1, 4'b0000, "pre_mid_reset");
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_now("reset_async_mid");
        drive_cycle(1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, "reset_mid_held");
        m_sel = 2'd0;
        // The first enabled edge after reset scans from index 1.
        model_step(1'b1, 4'b0000, "post_reset_first");
        model_step(1'b1, 4'b0000, "post_reset_second");

        // Random enable and empty flags.
        for (int i = 0; i < 1000; i++) begin
            model_step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), "random");
        end

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/round_robin_tester.md
ROUND_ROBIN_TESTER -- requirements
Module: round_robin_tester

Interface
REQ-001: Parameter QUEUE_QUANTITY, default 4, number of arbitrated queues; the block SHALL support only the value 4 (selector width fixed at 2).
REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003: rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004: enb  input  1  arbitration enable; high lets the arbiter advance.
REQ-005: buf_empty  input  4  per-queue empty flags; bit i high means queue i has no data.
REQ-006: selector  output  2  index of the queue granted by the behavioural arbiter, registered.
REQ-007: out_enb  output  1  grant-valid from the behavioural arbiter, registered.
REQ-008: sint_selector  output  2  index of the queue granted by the structural (gate-level-equivalent) arbiter, registered.
REQ-009: sint_out_enb  output  1  grant-valid from the structural arbiter, registered.

Function
REQ-010: The block SHALL contain two independent 4-queue round-robin arbiters, each driven by the same clk, rst, enb and buf_empty: a behavioural arbiter driving selector/out_enb and a structural one, built only from basic cells (flip-flops, logic gates), driving sint_selector/sint_out_enb.
REQ-011: Both arbiters SHALL be cycle-exact equivalent; sint_selector SHALL equal selector and sint_out_enb SHALL equal out_enb on every cycle, including during and after reset.
REQ-012: Each rising edge with rst high and enb high: the arbiter SHALL scan indices (S+1), (S+2), (S+3), S modulo 4, where S is the current selector, and pick the first index whose buf_empty bit is 0.
REQ-013: If an index is found, selector SHALL load it and out_enb SHALL be 1 in the same edge (latency one clock from buf_empty to grant).
REQ-014: If all four buf_empty bits are 1, selector SHALL hold and out_enb SHALL be 0.
REQ-015: With enb low, selector SHALL hold and out_enb SHALL be 0 at the next edge.
REQ-016: Wrap-around: after index 3 the scan SHALL continue at index 0; a single non-empty queue SHALL be granted on every enabled cycle (selector constant, out_enb 1).
REQ-017: buf_empty changes SHALL affect only the next edge; no combinational path from inputs to outputs.
REQ-018: Empty queues SHALL be skipped without spending a cycle on them.

Reset
REQ-019: While rst is low, selector and sint_selector SHALL be 2'b00 and out_enb and sint_out_enb SHALL be 0, asynchronously, independent of clk.
REQ-020: Reset asserted mid-operation SHALL force the reset values immediately; after rst rises, the first enabled edge SHALL scan starting from index 1.

Verification
REQ-021: rst low, then high, enb=1, buf_empty=4'b0000 -> selector 1,2,3,0,1,... on consecutive edges, out_enb=1 throughout.
REQ-022: buf_empty=4'b0001 while cycling -> selector sequence 1,2,3,1,2,3 (0 skipped), out_enb=1; clearing bit 0 again restores 0 into the rotation.
REQ-023: buf_empty=4'b1111 -> out_enb=0 next edge, selector holds last value; then buf_empty=4'b1011 -> selector=2, out_enb=1 next edge.
REQ-024: enb=0 for 3 cycles -> selector frozen, out_enb=0; enb=1 -> rotation resumes from the frozen index.
REQ-025: Pull rst low between edges mid-rotation -> all four outputs 0 immediately without a clock edge.
REQ-026: All scenarios above and random buf_empty/enb for 1000 cycles -> sint_selector==selector and sint_out_enb==out_enb every cycle.
